// File: rtl/vga_draw_scheduler.sv
// Frame-paced arbiter sharing the VGA pixel-write port among the wall, bullet and player drawers.
// Units are scanned in fixed order each frame, so the player is drawn last and lands on top.
module vga_draw_scheduler #(
    parameter int unsigned FRAME_CYCLES = 833334,
    parameter int unsigned MAX_GRANT    = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [2:0]  pix_valid,
    input  logic [23:0] x_in,
    input  logic [20:0] y_in,
    input  logic [8:0]  color_in,
    output logic [2:0]  grant,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  color_out,
    output logic        plot,
    output logic        frame_start,
    output logic        overrun,
    output logic        timeout
);

    localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned WdW  = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(MAX_GRANT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StGrant
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [WdW-1:0]  wd_q;
    logic [1:0]      idx_q;
    logic [2:0]      grant_q;
    logic [7:0]      x_q;
    logic [6:0]      y_q;
    logic [2:0]      color_q;
    logic            plot_q;
    logic            frame_start_q;
    logic            overrun_q;
    logic            timeout_q;

    logic       tick;
    logic       sel_req;
    logic       sel_done;
    logic       sel_pv;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_c;
    logic       release_now;

    assign tick = (cnt_q == CntLast);

    // Mux out the slice belonging to the unit currently indexed by the scan.
    always_comb begin
        sel_req  = 1'b0;
        sel_done = 1'b0;
        sel_pv   = 1'b0;
        sel_x    = 8'd0;
        sel_y    = 7'd0;
        sel_c    = 3'd0;
        unique case (idx_q)
            2'd0: begin
                sel_req  = req[0];
                sel_done = done[0];
                sel_pv   = pix_valid[0];
                sel_x    = x_in[7:0];
                sel_y    = y_in[6:0];
                sel_c    = color_in[2:0];
            end
            2'd1: begin
                sel_req  = req[1];
                sel_done = done[1];
                sel_pv   = pix_valid[1];
                sel_x    = x_in[15:8];
                sel_y    = y_in[13:7];
                sel_c    = color_in[5:3];
            end
            2'd2: begin
                sel_req  = req[2];
                sel_done = done[2];
                sel_pv   = pix_valid[2];
                sel_x    = x_in[23:16];
                sel_y    = y_in[20:14];
                sel_c    = color_in[8:6];
            end
            default: begin
                sel_req = 1'b0;
            end
        endcase
    end

    assign release_now = sel_done || (wd_q == WdLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wd_q          <= '0;
            idx_q         <= 2'd0;
            grant_q       <= 3'b000;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            color_q       <= 3'd0;
            plot_q        <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            cnt_q         <= tick ? '0 : cnt_q + 1'b1;
            frame_start_q <= 1'b0;
            plot_q        <= 1'b0;

            // A missed frame is only flagged; the running scan is never restarted.
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q       <= StScan;
                        idx_q         <= 2'd0;
                        frame_start_q <= 1'b1;
                    end
                end
                StScan: begin
                    if (sel_req) begin
                        state_q <= StGrant;
                        grant_q <= 3'b001 << idx_q;
                        wd_q    <= '0;
                    end else if (idx_q == 2'd2) begin
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StGrant: begin
                    x_q     <= sel_x;
                    y_q     <= sel_y;
                    color_q <= sel_c;
                    plot_q  <= sel_pv;
                    wd_q    <= wd_q + 1'b1;
                    if (release_now) begin
                        grant_q <= 3'b000;
                        if (!sel_done) begin
                            timeout_q <= 1'b1;
                        end
                        if (idx_q == 2'd2) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StScan;
                            idx_q   <= idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 3'b000;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign color_out   = color_q;
    assign plot        = plot_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: stimulus queues expected pixels and grants,
// a negedge monitor pops and compares them; a second instance with a long watchdog covers overrun.
module tb_vga_draw_scheduler;

    localparam int unsigned FC  = 16;
    localparam int unsigned MG  = 8;
    localparam int unsigned MG2 = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  req, done, pv_main, pix_valid;
    logic [1:0]  noise = 2'b00;
    logic        noise_en = 1'b0;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  color_in;
    logic [2:0]  grant, color_out;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic        plot, frame_start, overrun, timeout;

    logic        reset2;
    logic [2:0]  req2, done2, pv2;
    logic [23:0] x_in2;
    logic [20:0] y_in2;
    logic [8:0]  color_in2;
    logic [2:0]  grant2, color_out2;
    logic [7:0]  x_out2;
    logic [6:0]  y_out2;
    logic        plot2, frame_start2, overrun2, timeout2;

    assign pix_valid = pv_main | {1'b0, noise};

    // Wall and bullet strobes toggle freely to prove non-granted units never plot.
    always @(posedge clk) noise <= noise_en ? ~noise : 2'b00;

    vga_draw_scheduler #(.FRAME_CYCLES(FC), .MAX_GRANT(MG)) u_dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .pix_valid(pix_valid),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(grant), .x_out(x_out),
        .y_out(y_out), .color_out(color_out), .plot(plot), .frame_start(frame_start),
        .overrun(overrun), .timeout(timeout)
    );

    vga_draw_scheduler #(.FRAME_CYCLES(FC), .MAX_GRANT(MG2)) u_dut_ovr (
        .clk(clk), .reset(reset2), .req(req2), .done(done2), .pix_valid(pv2),
        .x_in(x_in2), .y_in(y_in2), .color_in(color_in2), .grant(grant2), .x_out(x_out2),
        .y_out(y_out2), .color_out(color_out2), .plot(plot2), .frame_start(frame_start2),
        .overrun(overrun2), .timeout(timeout2)
    );

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic [31:0] cyc;
    } pix_t;

    pix_t        pix_q[$];
    logic [2:0]  gnt_q[$];
    logic [2:0]  gnt_prev = 3'b000;
    logic [31:0] cyc = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int n);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen within %0d cycles", name, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon();
        pix_t e;
        if (plot === 1'b1) begin
            if (pix_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL plot_unexpected: plot=1 x=%0d, expected no plot", x_out);
            end else begin
                e = pix_q.pop_front();
                chk("plot_x", x_out, e.x);
                chk("plot_y", y_out, e.y);
                chk("plot_color", color_out, e.c);
                chk("plot_cycle", cyc, e.cyc);
            end
        end
        if (grant !== gnt_prev) begin
            if (grant !== 3'b000) begin
                chk("grant_onehot", $onehot(grant), 1);
                chk("grant_gap", gnt_prev, 0);
                if (gnt_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL grant_unexpected: got %b, expected no grant", grant);
                end else begin
                    chk("grant_seq", grant, gnt_q.pop_front());
                end
            end
            gnt_prev = grant;
        end
    endtask

    task automatic wait_grant(input int u, output int n);
        n = 0;
        while (grant[u] !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (grant[u] !== 1'b1) bound_fail("wait_grant", n);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < 64);
        if (frame_start !== 1'b1) bound_fail("wait_frame_start", n);
    endtask

    task automatic wait_fs2(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start2 !== 1'b1 && n < 64);
        if (frame_start2 !== 1'b1) bound_fail("wait_frame_start2", n);
    endtask

    task automatic serve(input int u, input int npix, input logic [7:0] xs,
                         input logic [6:0] ys, input logic [2:0] cs, input bit give_done);
        int n;
        wait_grant(u, n);
        for (int i = 0; i < npix; i++) begin
            pv_main[u] = 1'b1;
            x_in[8*u +: 8]     = xs;
            y_in[7*u +: 7]     = ys;
            color_in[3*u +: 3] = cs;
            pix_q.push_back('{x: xs, y: ys, c: cs, cyc: cyc + 32'd1});
            step();
        end
        pv_main[u] = 1'b0;
        if (give_done) begin
            done[u] = 1'b1;
            step();
            done[u] = 1'b0;
        end
    endtask

    task automatic run_tests();
        int n;
        reset = 1'b1; req = 3'b111; done = 3'b000; pv_main = 3'b000;
        x_in = '0; y_in = '0; color_in = '0;
        reset2 = 1'b1; req2 = 3'b000; done2 = 3'b000; pv2 = 3'b000;
        x_in2 = 24'd77; y_in2 = 21'd33; color_in2 = 9'd5;

        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_color", color_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);

        reset = 1'b0;
        wait_fs(n);
        chk("first_frame_start_delay", n, 16);

        // All three units, two pixels each, released by done.
        gnt_q.push_back(3'b001);
        gnt_q.push_back(3'b010);
        gnt_q.push_back(3'b100);
        serve(0, 2, 8'd10, 7'd5, 3'd1, 1'b1);
        serve(1, 2, 8'd20, 7'd6, 3'd2, 1'b1);
        serve(2, 2, 8'd30, 7'd7, 3'd4, 1'b1);

        // Player only, with wall/bullet strobes toggling on junk coordinates.
        req = 3'b100;
        x_in[15:0] = 16'h6363;
        noise_en = 1'b1;
        wait_fs(n);
        chk("idle_until_next_frame", n, 4);
        gnt_q.push_back(3'b100);
        n = 0;
        while (grant === 3'b000 && n < 16) begin
            step();
            n++;
        end
        chk("player_grant_delay", n, 3);
        chk("player_only_grant", grant, 3'b100);
        serve(2, 1, 8'd31, 7'd8, 3'd4, 1'b1);
        noise_en = 1'b0;

        // Watchdog release: done withheld, strobe kept high past the drop.
        chk("timeout_before", timeout, 0);
        gnt_q.push_back(3'b100);
        wait_grant(2, n);
        for (int i = 0; i < 8; i++) begin
            chk("wd_grant_held", grant, 3'b100);
            pv_main[2] = 1'b1;
            x_in[23:16]    = 8'(40 + i);
            y_in[20:14]    = 7'd20;
            color_in[8:6]  = 3'd6;
            pix_q.push_back('{x: 8'(40 + i), y: 7'd20, c: 3'd6, cyc: cyc + 32'd1});
            step();
        end
        chk("wd_grant_dropped", grant, 0);
        chk("timeout_set", timeout, 1);
        step();
        step();
        pv_main[2] = 1'b0;

        gnt_q.push_back(3'b100);
        serve(2, 2, 8'd50, 7'd9, 3'd3, 1'b1);
        chk("timeout_sticky", timeout, 1);
        chk("overrun_clear", overrun, 0);

        // Reset in the middle of a grant with the strobe high.
        gnt_q.push_back(3'b100);
        wait_grant(2, n);
        pv_main[2] = 1'b1;
        x_in[23:16] = 8'd60; y_in[20:14] = 7'd10; color_in[8:6] = 3'd5;
        pix_q.push_back('{x: 8'd60, y: 7'd10, c: 3'd5, cyc: cyc + 32'd1});
        step();
        reset = 1'b1;
        step();
        chk("midrst_grant", grant, 0);
        chk("midrst_plot", plot, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_overrun", overrun, 0);
        reset = 1'b0; pv_main = 3'b000; req = 3'b000;

        // Long wall draw on the second instance spans a frame tick.
        req2 = 3'b001;
        step();
        reset2 = 1'b0;
        wait_fs2(n);
        chk("ovr_first_frame_start", n, 16);
        n = 0;
        while (grant2 === 3'b000 && n < 16) begin
            step();
            n++;
        end
        chk("ovr_grant_delay", n, 1);
        chk("ovr_grant", grant2, 3'b001);
        n = 0;
        while (overrun2 !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk("ovr_tick_cycle", n, 15);
        chk("ovr_no_restart", frame_start2, 0);
        chk("ovr_grant_kept", grant2, 3'b001);
        done2[0] = 1'b1;
        step();
        done2[0] = 1'b0;
        chk("ovr_released", grant2, 0);
        wait_fs2(n);
        chk("ovr_next_frame", n, 15);
        chk("ovr_sticky", overrun2, 1);
        chk("ovr_no_timeout", timeout2, 0);
        step();
        chk("ovr_regrant", grant2, 3'b001);
        pv2[0] = 1'b1;
        step();
        chk("ovr_plot", plot2, 1);
        reset2 = 1'b1;
        step();
        chk("ovr_rst_grant", grant2, 0);
        chk("ovr_rst_plot", plot2, 0);
        chk("ovr_rst_overrun", overrun2, 0);
        reset2 = 1'b0; pv2 = 3'b000; req2 = 3'b000;

        repeat (4) step();
        chk("pix_queue_drained", pix_q.size(), 0);
        chk("grant_queue_drained", gnt_q.size(), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon();
            end
            begin
                #100000;
                bound_fail("global_time_limit", 10000);
            end
            run_tests();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
